// File: rtl/aesl_deadlock_param_monitor_if.sv
// ============================================================================
// Module      : aesl_deadlock_param_monitor_if
// Description : Stall inputs and deadlock report outputs of the monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface aesl_deadlock_param_monitor_if #(
  parameter int NUM_PROC = 5,
  parameter int NUM_AXIS = 2
) ();
  logic                    clear;
  logic [NUM_AXIS-1:0]     axis_block_sigs;
  logic [NUM_PROC-1:0]     inst_idle_sigs;
  logic [NUM_PROC-1:0]     inst_block_sigs;
  logic [2*NUM_AXIS-1:0]   axis_block_info;
  logic [NUM_PROC-1:0]     block_proc_vec;
  logic                    block;

  modport master (
    output clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    input  axis_block_info, block_proc_vec, block
  );

  modport slave (
    input  clear, axis_block_sigs, inst_idle_sigs, inst_block_sigs,
    output axis_block_info, block_proc_vec, block
  );
endinterface

`default_nettype wire

// File: rtl/aesl_deadlock_param_monitor.sv
// ============================================================================
// Module      : aesl_deadlock_param_monitor
// Description : Dataflow deadlock detector driven by AXIS stall signals.
//               Define AESL_DEADLOCK_STICKY_EN to hold a report until clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aesl_deadlock_param_monitor #(
  parameter int                           NUM_PROC     = 5,
  parameter int                           NUM_AXIS     = 2,
  parameter int                           STALL_CYCLES = 1,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MAP     = '0,
  parameter logic [NUM_AXIS-1:0]          AXIS_DIR     = '0
) (
  input  wire logic                      clock,
  input  wire logic                      reset,
  aesl_deadlock_param_monitor_if.slave   mon
);

  localparam logic [1:0]  c_ST_IDLE    = 2'd0;
  localparam logic [1:0]  c_ST_ARMING  = 2'd1;
  localparam logic [1:0]  c_ST_BLOCKED = 2'd2;
  localparam logic [15:0] c_STALL      = 16'(STALL_CYCLES);
  localparam logic [15:0] c_STALL_M1   = c_STALL - 16'd1;

  logic [1:0]            r_state;
  logic [15:0]           r_cnt;
  logic [2*NUM_AXIS-1:0] r_info;
  logic [NUM_PROC-1:0]   r_vec;

  logic [NUM_AXIS-1:0]   w_used;
  logic [NUM_AXIS-1:0]   w_axis_masked;
  logic [NUM_PROC-1:0]   w_proc_axis_blk;
  logic [NUM_PROC-1:0]   w_stopped;
  logic [2*NUM_AXIS-1:0] w_code;
  logic                  w_cond;
  logic                  w_exit;

  // Channels no process maps to are ignored entirely.
  always_comb begin
    w_used = '0;
    for (int p = 0; p < NUM_PROC; p++) begin
      w_used = w_used | AXIS_MAP[p*NUM_AXIS +: NUM_AXIS];
    end
    w_axis_masked = mon.axis_block_sigs & w_used;
    for (int p = 0; p < NUM_PROC; p++) begin
      w_proc_axis_blk[p] = |(w_axis_masked & AXIS_MAP[p*NUM_AXIS +: NUM_AXIS]);
    end
    w_stopped = mon.inst_idle_sigs | mon.inst_block_sigs | w_proc_axis_blk;
    w_cond    = (&w_stopped) & (|w_proc_axis_blk);
  end

  generate
    for (genvar a = 0; a < NUM_AXIS; a++) begin : g_code
      assign w_code[2*a+1:2*a] = !w_axis_masked[a] ? 2'b00 :
                                 (AXIS_DIR[a] ? 2'b01 : 2'b10);
    end
  endgenerate

`ifdef AESL_DEADLOCK_STICKY_EN
  assign w_exit = mon.clear;
`else
  assign w_exit = mon.clear | ~w_cond;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= 16'd0;
      r_info  <= '0;
      r_vec   <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (mon.clear || !w_cond) begin
            r_cnt <= 16'd0;
          end else if (c_STALL_M1 == 16'd0) begin
            r_state <= c_ST_BLOCKED;
            r_cnt   <= c_STALL;
            r_info  <= w_code;
            r_vec   <= w_proc_axis_blk;
          end else begin
            r_state <= c_ST_ARMING;
            r_cnt   <= 16'd1;
          end
        end
        c_ST_ARMING: begin
          if (mon.clear || !w_cond) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 16'd0;
          end else if (r_cnt == c_STALL_M1) begin
            r_state <= c_ST_BLOCKED;
            r_cnt   <= c_STALL;
            r_info  <= w_code;
            r_vec   <= w_proc_axis_blk;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        c_ST_BLOCKED: begin
          // Captured report stays frozen until the state is left.
          if (w_exit) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= 16'd0;
            r_info  <= '0;
            r_vec   <= '0;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_cnt   <= 16'd0;
          r_info  <= '0;
          r_vec   <= '0;
        end
      endcase
    end
  end

  assign mon.block           = (r_state == c_ST_BLOCKED);
  assign mon.axis_block_info = r_info;
  assign mon.block_proc_vec  = r_vec;

endmodule

`default_nettype wire

// File: tb/tb_aesl_deadlock_param_monitor.sv
// ============================================================================
// Module      : tb_aesl_deadlock_param_monitor
// Description : Scoreboard bench for two monitor configurations (stall 1 / 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aesl_deadlock_param_monitor;

  localparam logic [9:0] c_MAP = 10'h204;
`ifdef AESL_DEADLOCK_STICKY_EN
  localparam bit c_STICKY = 1'b1;
`else
  localparam bit c_STICKY = 1'b0;
`endif

  logic clock;
  logic reset;

  aesl_deadlock_param_monitor_if #(.NUM_PROC(5), .NUM_AXIS(2)) ifa ();
  aesl_deadlock_param_monitor_if #(.NUM_PROC(5), .NUM_AXIS(2)) ifb ();

  aesl_deadlock_param_monitor #(
    .NUM_PROC(5), .NUM_AXIS(2), .STALL_CYCLES(1), .AXIS_MAP(c_MAP), .AXIS_DIR(2'b00)
  ) dut_a (.clock(clock), .reset(reset), .mon(ifa));

  aesl_deadlock_param_monitor #(
    .NUM_PROC(5), .NUM_AXIS(2), .STALL_CYCLES(4), .AXIS_MAP(c_MAP), .AXIS_DIR(2'b01)
  ) dut_b (.clock(clock), .reset(reset), .mon(ifb));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: counts consecutive stalled cycles per configuration.
  logic       m_blk  [2];
  logic [3:0] m_info [2];
  logic [4:0] m_vec  [2];
  int         m_run  [2];
  int         m_stall[2] = '{1, 4};
  logic [1:0] m_dir  [2] = '{2'b00, 2'b01};
  logic [19:0] sb_q[$];

  task automatic model_step(input logic rst_n, input logic clr, input logic [4:0] idle,
                            input logic [4:0] iblk, input logic [1:0] axis);
    logic [4:0] axb;
    logic [1:0] used;
    logic       cond;
    axb  = '0;
    used = '0;
    for (int p = 0; p < 5; p++) begin
      for (int a = 0; a < 2; a++) begin
        if (c_MAP[p*2+a]) begin
          used[a] = 1'b1;
          if (axis[a]) axb[p] = 1'b1;
        end
      end
    end
    cond = ((idle | iblk | axb) == 5'h1f) && (axb != 5'h00);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_blk[d] = 1'b0; m_info[d] = '0; m_vec[d] = '0; m_run[d] = 0;
      end else if (m_blk[d]) begin
        if (clr || (!c_STICKY && !cond)) begin
          m_blk[d] = 1'b0; m_info[d] = '0; m_vec[d] = '0; m_run[d] = 0;
        end
      end else if (clr || !cond) begin
        m_run[d] = 0;
      end else begin
        m_run[d]++;
        if (m_run[d] >= m_stall[d]) begin
          m_blk[d] = 1'b1;
          m_vec[d] = axb;
          for (int a = 0; a < 2; a++) begin
            m_info[d][2*a +: 2] = !(axis[a] && used[a]) ? 2'b00 :
                                  (m_dir[d][a] ? 2'b01 : 2'b10);
          end
        end
      end
    end
    sb_q.push_back({m_blk[0], m_info[0], m_vec[0], m_blk[1], m_info[1], m_vec[1]});
  endtask

  task automatic drive_cycle(input logic rst_n, input logic clr, input logic [4:0] idle,
                             input logic [4:0] iblk, input logic [1:0] axis);
    logic [19:0] exp;
    reset = rst_n;
    ifa.clear = clr; ifa.inst_idle_sigs = idle; ifa.inst_block_sigs = iblk; ifa.axis_block_sigs = axis;
    ifb.clear = clr; ifb.inst_idle_sigs = idle; ifb.inst_block_sigs = iblk; ifb.axis_block_sigs = axis;
    model_step(rst_n, clr, idle, iblk, axis);
    @(posedge clock);
    #1;
    if (sb_q.size() == 0) begin
      check_value("sb_empty", 32'd0, 32'd1);
    end else begin
      exp = sb_q.pop_front();
      check_value("sb_dut_a", 32'({ifa.block, ifa.axis_block_info, ifa.block_proc_vec}), 32'(exp[19:10]));
      check_value("sb_dut_b", 32'({ifb.block, ifb.axis_block_info, ifb.block_proc_vec}), 32'(exp[9:0]));
    end
  endtask

  // Named input patterns: both channels stalled, channel 0 only, no stall.
  localparam logic [4:0] c_IDLE_C2 = 5'b01101;
  localparam logic [4:0] c_IDLE_C0 = 5'b11101;

  task automatic cyc_c2(input logic clr);
    drive_cycle(1'b1, clr, c_IDLE_C2, 5'b0, 2'b11);
  endtask
  task automatic cyc_n(input logic clr);
    drive_cycle(1'b1, clr, c_IDLE_C2, 5'b0, 2'b00);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      m_blk[d] = 1'b0; m_info[d] = '0; m_vec[d] = '0; m_run[d] = 0;
    end
    // Reset with clear and cond asserted simultaneously.
    drive_cycle(1'b0, 1'b1, c_IDLE_C2, 5'b0, 2'b11);
    drive_cycle(1'b0, 1'b1, c_IDLE_C2, 5'b0, 2'b11);
    check_value("rst_block_a", 32'(ifa.block), 32'd0);
    check_value("rst_info_b", 32'(ifb.axis_block_info), 32'd0);
    cyc_n(1'b0);
    cyc_n(1'b0);

    // Stall of one cycle on the stall-1 instance.
    cyc_c2(1'b0);
    check_value("s1_block", 32'(ifa.block), 32'd1);
    check_value("s1_vec", 32'(ifa.block_proc_vec), 32'h12);
    check_value("s1_info", 32'(ifa.axis_block_info), 32'hA);
    cyc_n(1'b0);
    check_value("s1_drop", 32'(ifa.block), 32'(c_STICKY));
    cyc_n(1'b1);
    check_value("s1_clear", 32'(ifa.block), 32'd0);

    // Three stalled cycles are not enough for the stall-4 instance.
    for (int i = 0; i < 3; i++) cyc_c2(1'b0);
    check_value("s4_three", 32'(ifb.block), 32'd0);
    cyc_n(1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc_c2(1'b0);
      check_value("s4_four", 32'(ifb.block), (i == 3) ? 32'd1 : 32'd0);
    end
    check_value("s4_info_both", 32'(ifb.axis_block_info), 32'h9);
    check_value("s4_vec", 32'(ifb.block_proc_vec), 32'h12);
    cyc_n(1'b1);
    check_value("s4_cleared", 32'(ifb.axis_block_info), 32'd0);

    // Only channel 0 stalled.
    for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, c_IDLE_C0, 5'b0, 2'b01);
    check_value("ch0_info_b", 32'(ifb.axis_block_info), 32'h1);
    check_value("ch0_info_a", 32'(ifa.axis_block_info), 32'h2);
    check_value("ch0_vec_b", 32'(ifb.block_proc_vec), 32'h02);
    cyc_n(1'b0);
    check_value("drop_b", 32'(ifb.block), 32'(c_STICKY));
    cyc_n(1'b1);
    check_value("clear_b", 32'(ifb.block), 32'd0);

    // Reset while blocked, with clear and cond also asserted.
    for (int i = 0; i < 4; i++) cyc_c2(1'b0);
    drive_cycle(1'b0, 1'b1, c_IDLE_C2, 5'b0, 2'b11);
    check_value("rstblk_b", 32'({ifb.block, ifb.axis_block_info, ifb.block_proc_vec}), 32'd0);

    // Reset while arming at count 2 must restart the count.
    cyc_n(1'b0);
    cyc_c2(1'b0);
    cyc_c2(1'b0);
    drive_cycle(1'b0, 1'b0, c_IDLE_C2, 5'b0, 2'b11);
    check_value("rstarm_b", 32'(ifb.block), 32'd0);
    for (int i = 0; i < 3; i++) cyc_c2(1'b0);
    check_value("rstarm_restart", 32'(ifb.block), 32'd0);
    cyc_c2(1'b0);
    check_value("rstarm_done", 32'(ifb.block), 32'd1);

    // Clear beats cond while arming.
    cyc_n(1'b1);
    cyc_c2(1'b0);
    cyc_c2(1'b0);
    cyc_c2(1'b1);
    for (int i = 0; i < 3; i++) cyc_c2(1'b0);
    check_value("clrarm_b", 32'(ifb.block), 32'd0);
    cyc_c2(1'b0);
    check_value("clrarm_done", 32'(ifb.block), 32'd1);
    cyc_n(1'b1);

    // All idle, nothing stalled on AXIS.
    for (int i = 0; i < 100; i++) drive_cycle(1'b1, 1'b0, 5'h1f, 5'b0, 2'b00);
    check_value("idle100_a", 32'(ifa.block), 32'd0);

    // Random traffic biased toward stall conditions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] idle;
      logic [4:0] iblk;
      idle = ($urandom_range(0, 3) == 0) ? 5'($urandom) : c_IDLE_C2 | 5'($urandom & 32'h12);
      iblk = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
      drive_cycle(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                  idle, iblk, 2'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
